// File: rtl/icache_pkg.sv
// Shared constants and types for the direct-mapped instruction cache.
// Holds the default index width, the FSM state encoding and the RVC quadrant test.
package icache_pkg;

    localparam int ICACHE_IDX_W = 8;

    typedef enum logic {
        IC_IDLE = 1'b0,
        IC_WAIT = 1'b1
    } ic_state_t;

    localparam logic [1:0] QUAD_FULL = 2'b11;

    // Quadrant 2'b11 marks a 32-bit encoding; every other quadrant is compressed.
    function automatic logic is_full(input logic [1:0] quad);
        return quad == QUAD_FULL;
    endfunction

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage for the icache.
// Provides two combinational word read ports and one synchronous refill write port.
module icache_array
    import icache_pkg::*;
#(
    parameter int IDX_W = ICACHE_IDX_W
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [29:0] rd_waddr0,
    input  logic [29:0] rd_waddr1,
    output logic        hit0,
    output logic [31:0] data0,
    output logic        hit1,
    output logic [31:0] data1,
    input  logic        wr_en,
    input  logic [29:0] wr_waddr,
    input  logic [31:0] wr_data
);

    localparam int LINES = 1 << IDX_W;
    localparam int TAG_W = 30 - IDX_W;

    logic [LINES-1:0] valid;
    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [31:0]      data_mem [LINES];

    logic [IDX_W-1:0] idx0, idx1, wr_idx;

    assign idx0   = rd_waddr0[IDX_W-1:0];
    assign idx1   = rd_waddr1[IDX_W-1:0];
    assign wr_idx = wr_waddr[IDX_W-1:0];

    assign hit0  = valid[idx0] && (tag_mem[idx0] == rd_waddr0[29:IDX_W]);
    assign hit1  = valid[idx1] && (tag_mem[idx1] == rd_waddr1[29:IDX_W]);
    assign data0 = data_mem[idx0];
    assign data1 = data_mem[idx1];

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    // Tag and data need no reset: a line is only trusted once its valid bit is set.
    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            tag_mem[wr_idx]  <= wr_waddr[29:IDX_W];
            data_mem[wr_idx] <= wr_data;
        end
    end

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache with halfword-aligned RV32IC fetch.
// Hits answer combinationally; misses refill one word at a time from memory.
module icache
    import icache_pkg::*;
#(
    parameter int IDX_W = ICACHE_IDX_W
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] in_PC,
    input  logic        ask_for,
    output logic        give_you,
    output logic [31:0] g_ins,
    output logic        mem_ask,
    output logic [31:0] mem_addr,
    input  logic        mem_done,
    input  logic [31:0] mem_data
);

    ic_state_t   state, state_next;
    logic        ask_next;
    logic [29:0] miss_waddr, miss_next;
    logic        wr_en;

    logic [29:0] w0, w1;
    logic        hit0, hit1;
    logic [31:0] d0, d1;
    logic [1:0]  quad;
    logic        straddle;
    logic        line_hit;

    logic        unused_bits;
    assign unused_bits = in_PC[0] ^ (^d1[31:16]);

    // Word addresses are kept without their two zero bits, so w1 wraps naturally to 0.
    assign w0 = in_PC[31:2];
    assign w1 = w0 + 30'd1;

    icache_array #(.IDX_W(IDX_W)) u_array (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .rd_waddr0 (w0),
        .rd_waddr1 (w1),
        .hit0      (hit0),
        .data0     (d0),
        .hit1      (hit1),
        .data1     (d1),
        .wr_en     (wr_en),
        .wr_waddr  (miss_waddr),
        .wr_data   (mem_data)
    );

    assign quad     = in_PC[1] ? d0[17:16] : d0[1:0];
    assign straddle = in_PC[1] & is_full(quad);
    assign line_hit = hit0 & (!straddle | hit1);
    assign give_you = rdy_in & ask_for & line_hit;

    always_comb begin
        g_ins = d0;
        if (in_PC[1]) begin
            g_ins = straddle ? {d1[15:0], d0[31:16]} : {16'h0000, d0[31:16]};
        end
    end

    // A miss on w0 is refilled first; w1 is only requested once w0 is resident.
    always_comb begin
        state_next = state;
        ask_next   = mem_ask;
        miss_next  = miss_waddr;
        wr_en      = 1'b0;
        case (state)
            IC_IDLE: begin
                if (ask_for && !line_hit) begin
                    state_next = IC_WAIT;
                    ask_next   = 1'b1;
                    miss_next  = hit0 ? w1 : w0;
                end
            end
            IC_WAIT: begin
                if (mem_done) begin
                    state_next = IC_IDLE;
                    ask_next   = 1'b0;
                    wr_en      = rdy_in;
                end
            end
            default: begin
                state_next = IC_IDLE;
                ask_next   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state      <= IC_IDLE;
            mem_ask    <= 1'b0;
            miss_waddr <= '0;
        end else if (rdy_in) begin
            state      <= state_next;
            mem_ask    <= ask_next;
            miss_waddr <= miss_next;
        end
    end

    assign mem_addr = {miss_waddr, 2'b00};

endmodule

// File: tb/tb_icache.sv
// Directed testbench for icache: a latency-3 memory model answers refills
// and each scenario checks delivered instructions and the refill addresses.
module tb_icache;

    logic        clk_in;
    logic        rst_in;
    logic        rdy_in;
    logic [31:0] in_PC;
    logic        ask_for;
    logic        give_you;
    logic [31:0] g_ins;
    logic        mem_ask;
    logic [31:0] mem_addr;
    logic        mem_done;
    logic [31:0] mem_data;

    int assertCount = 0;
    int failCount   = 0;
    logic [31:0] reqLog[$];

    icache #(.IDX_W(8)) dut (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .rdy_in   (rdy_in),
        .in_PC    (in_PC),
        .ask_for  (ask_for),
        .give_you (give_you),
        .g_ins    (g_ins),
        .mem_ask  (mem_ask),
        .mem_addr (mem_addr),
        .mem_done (mem_done),
        .mem_data (mem_data)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    function automatic logic [31:0] memWord(input logic [31:0] addr);
        case (addr)
            32'h0000_0000: return 32'h0050_0093;
            32'h0000_0100: return 32'h4505_0001;
            32'h0000_01FC: return 32'h0513_0001;
            32'h0000_0200: return 32'h0000_0FF0;
            default:       return addr + 32'h1000_0003;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assertCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Memory model: 3 ready cycles of latency, pulses mem_done for one cycle.
    initial begin
        logic [31:0] reqAddr;
        int lat;
        mem_done = 1'b0;
        mem_data = '0;
        forever begin
            @(negedge clk_in);
            if (mem_ask && !rst_in) begin
                reqAddr = mem_addr;
                reqLog.push_back(reqAddr);
                lat = 0;
                while (lat < 3) begin
                    @(negedge clk_in);
                    if (rdy_in) lat++;
                    if (mem_ask) checkOutput("addr_hold", mem_addr, reqAddr);
                end
                mem_done = 1'b1;
                mem_data = memWord(reqAddr);
                @(negedge clk_in);
                mem_done = 1'b0;
                checkOutput("ask_gap", {31'b0, mem_ask}, 32'd0);
            end
        end
    end

    task automatic applyStimulus(input logic [31:0] pc, input logic ask);
        in_PC   = pc;
        ask_for = ask;
    endtask

    task automatic waitGive(output int cycles);
        cycles = 0;
        #1;
        while (!give_you && cycles < 60) begin
            @(negedge clk_in);
            #1;
            cycles++;
        end
    endtask

    task automatic waitAsk();
        int n = 0;
        #1;
        while (!mem_ask && n < 10) begin
            @(negedge clk_in);
            #1;
            n++;
        end
    endtask

    task automatic doReset();
        @(negedge clk_in);
        rst_in = 1'b1;
        applyStimulus(32'h0, 1'b0);
        @(negedge clk_in);
        rst_in = 1'b0;
        #1;
        checkOutput("rst_ask", {31'b0, mem_ask}, 32'd0);
        checkOutput("rst_addr", mem_addr, 32'd0);
    endtask

    task automatic fetchAndCheck(input string tag, input logic [31:0] pc, input logic [31:0] expIns,
                                 input int expReqs, input logic [31:0] a0, input logic [31:0] a1);
        int cycles;
        @(negedge clk_in);
        reqLog.delete();
        applyStimulus(pc, 1'b1);
        waitGive(cycles);
        checkOutput({tag, "_gv"}, {31'b0, give_you}, 32'd1);
        checkOutput({tag, "_ins"}, g_ins, expIns);
        checkOutput({tag, "_nreq"}, reqLog.size(), expReqs);
        if (expReqs == 0) checkOutput({tag, "_lat"}, cycles, 32'd0);
        if (expReqs >= 1 && reqLog.size() >= 1) checkOutput({tag, "_req0"}, reqLog[0], a0);
        if (expReqs >= 2 && reqLog.size() >= 2) checkOutput({tag, "_req1"}, reqLog[1], a1);
        @(negedge clk_in);
        applyStimulus(pc, 1'b0);
    endtask

    initial begin
        int cycles;
        rst_in = 1'b0;
        rdy_in = 1'b1;
        applyStimulus(32'h0, 1'b0);
        doReset();

        @(negedge clk_in);
        applyStimulus(32'h0, 1'b1);
        #1;
        checkOutput("cold_gv0", {31'b0, give_you}, 32'd0);
        applyStimulus(32'h0, 1'b0);

        fetchAndCheck("cold", 32'h0, 32'h0050_0093, 1, 32'h0, 32'h0);
        fetchAndCheck("rehit", 32'h0, 32'h0050_0093, 0, 32'h0, 32'h0);
        fetchAndCheck("rvc", 32'h102, 32'h0000_4505, 1, 32'h100, 32'h0);
        fetchAndCheck("strad", 32'h1FE, 32'h0FF0_0513, 2, 32'h1FC, 32'h200);
        fetchAndCheck("strad_hit", 32'h1FE, 32'h0FF0_0513, 0, 32'h0, 32'h0);
        fetchAndCheck("confl", 32'h400, 32'h1000_0403, 1, 32'h400, 32'h0);
        fetchAndCheck("confl0", 32'h0, 32'h0050_0093, 1, 32'h0, 32'h0);

        // PC moves to 0x80 while 0x40 is being refilled.
        @(negedge clk_in);
        reqLog.delete();
        applyStimulus(32'h40, 1'b1);
        waitAsk();
        checkOutput("pcchg_ask", {31'b0, mem_ask}, 32'd1);
        @(negedge clk_in);
        applyStimulus(32'h80, 1'b1);
        #1;
        checkOutput("pcchg_gv0", {31'b0, give_you}, 32'd0);
        waitGive(cycles);
        checkOutput("pcchg_gv", {31'b0, give_you}, 32'd1);
        checkOutput("pcchg_ins", g_ins, 32'h1000_0083);
        checkOutput("pcchg_nreq", reqLog.size(), 32'd2);
        if (reqLog.size() >= 2) checkOutput("pcchg_req1", reqLog[1], 32'h80);
        @(negedge clk_in);
        applyStimulus(32'h80, 1'b0);
        fetchAndCheck("pcchg_old", 32'h40, 32'h1000_0043, 0, 32'h0, 32'h0);

        // Ready low freezes a pending refill and masks hits.
        @(negedge clk_in);
        reqLog.delete();
        applyStimulus(32'h300, 1'b1);
        waitAsk();
        @(negedge clk_in);
        rdy_in = 1'b0;
        repeat (5) @(negedge clk_in);
        #1;
        checkOutput("rdy_ask_held", {31'b0, mem_ask}, 32'd1);
        checkOutput("rdy_gv", {31'b0, give_you}, 32'd0);
        rdy_in = 1'b1;
        waitGive(cycles);
        checkOutput("rdy_ins", g_ins, 32'h1000_0303);
        @(negedge clk_in);
        rdy_in = 1'b0;
        #1;
        checkOutput("rdy_hit_mask", {31'b0, give_you}, 32'd0);
        rdy_in = 1'b1;
        #1;
        checkOutput("rdy_hit", {31'b0, give_you}, 32'd1);
        applyStimulus(32'h300, 1'b0);

        // Reset during a refill drops it and invalidates all lines.
        @(negedge clk_in);
        applyStimulus(32'h500, 1'b1);
        waitAsk();
        doReset();
        repeat (10) @(negedge clk_in);
        applyStimulus(32'h0, 1'b1);
        #1;
        checkOutput("rst_inval", {31'b0, give_you}, 32'd0);
        applyStimulus(32'h0, 1'b0);
        #1;
        checkOutput("rst_idle", {31'b0, mem_ask}, 32'd0);

        fetchAndCheck("wrap", 32'hFFFF_FFFE, 32'h0093_0FFF, 2, 32'hFFFF_FFFC, 32'h0);

        repeat (5) @(negedge clk_in);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation timeout");
    end

endmodule
